// File: rtl/pipeline_hazard_controller.sv
// Hazard request consumer: turns nop/flush codes into PC, IF/ID and ID/EX control,
// and keeps saturating stall/flush counters plus a sticky reserved-code flag.
module pipeline_hazard_controller #(
  parameter int unsigned PC_W         = 16,
  parameter int unsigned PC_INC       = 1,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       nop,
  input  logic [1:0]       flush,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  pc,
  output logic             if_id_en,
  output logic             if_id_clear,
  output logic             id_ex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             illegal_req
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [1:0]       flush_left_q, flush_left_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             illegal_q, illegal_d;
  logic             nop_req, flush_req;

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
    $error("pipeline_hazard_controller: FLUSH_CYCLES must be in 1..3");
  end

  assign nop_req   = (nop == 2'b01);
  assign flush_req = (flush == 2'b01);

  // A taken flush is tested first in every state, so RUN, STALL and FLUSH share
  // one redirect path; nop only matters once no flush is in progress.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q + PC_W'(PC_INC);
    flush_left_d = flush_left_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    illegal_d    = illegal_q | nop[1] | flush[1];
    if_id_en     = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_bubble = 1'b0;
    if (flush_req) begin
      pc_d         = branch_target;
      if_id_clear  = 1'b1;
      id_ex_bubble = 1'b1;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      if (FLUSH_CYCLES > 1) begin
        state_d      = S_FLUSH;
        flush_left_d = 2'(FLUSH_CYCLES - 1);
      end else begin
        state_d = S_RUN;
      end
    end else if (state_q == S_FLUSH) begin
      if_id_clear  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_left_d = flush_left_q - 2'd1;
      if (flush_left_q <= 2'd1) state_d = S_RUN;
    end else if (nop_req) begin
      pc_d         = pc_q;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
      state_d      = S_STALL;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      pc_q         <= PC_W'(RESET_PC);
      flush_left_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_left_q <= flush_left_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      illegal_q    <= illegal_d;
    end
  end

  assign pc          = pc_q;
  assign busy        = (state_q != S_RUN);
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign illegal_req = illegal_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Consumer side of the hazard request interface: takes the 2-bit nop (load-use stall) and flush (taken bne) codes from hazard detection and turns them into pipeline actions.
- Owns the PC register and drives IF/ID hold/clear and the ID/EX bubble.
- Sits between hazard detection and the fetch/decode pipeline registers.
- Also keeps saturating stall/flush event counters and a sticky error flag for reserved request codes.

Parameters:
- PC_W, 16, PC width in bits.
- PC_INC, 1, sequential PC increment.
- RESET_PC, 0, PC value loaded at reset.
- FLUSH_CYCLES, 1, cycles IF/ID is cleared per taken branch (legal range 1..3).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- nop  in  2  stall request; 2'b01 = load-use stall; 2'b00 = none; 2'b10/2'b11 reserved
- flush  in  2  flush request; 2'b01 = branch taken; 2'b00 = none; 2'b10/2'b11 reserved
- branch_target  in  PC_W  redirect address, valid when flush==2'b01
- pc  out  PC_W  current fetch address (registered)
- if_id_en  out  1  IF/ID register write enable
- if_id_clear  out  1  IF/ID register synchronous clear to NOP
- id_ex_bubble  out  1  insert NOP into ID/EX this cycle
- busy  out  1  high while state != RUN
- stall_count  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of redirects
- illegal_req  out  1  sticky; set when either input carries a reserved code

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: pc=RESET_PC, state=RUN, stall_count=0, flush_count=0, illegal_req=0, flush_left=0.
- Combinational outputs at reset: if_id_en=1, if_id_clear=0, id_ex_bubble=0.
- Decode: reserved codes are treated as 2'b00 for action and set illegal_req at the next edge. Only reset clears illegal_req.
- Control outputs are combinational from state and current requests (same-cycle response, zero latency). pc, state and counters update on the clk edge.
- States: RUN, STALL, FLUSH.
- RUN, no request:
  - pc <= pc+PC_INC, wrapping modulo 2^PC_W.
  - if_id_en=1, if_id_clear=0, id_ex_bubble=0.
- RUN, flush==01 (priority over nop):
  - pc <= branch_target; if_id_clear=1; id_ex_bubble=1; if_id_en=1.
  - flush_count++.
  - If FLUSH_CYCLES>1: flush_left <= FLUSH_CYCLES-1, go to FLUSH. Otherwise stay in RUN.
- RUN, nop==01 (flush absent):
  - pc holds; if_id_en=0; id_ex_bubble=1; stall_count++; go to STALL.
- STALL:
  - nop==01 continues: hold as above, one bubble per cycle, stall_count++ per cycle.
  - flush==01 arrives: abort the stall and act exactly as the RUN flush case. A pending stall is discarded.
  - No request: resume RUN behaviour in this same cycle (pc increments) and go to RUN.
- FLUSH:
  - if_id_clear=1, id_ex_bubble=1, pc <= pc+PC_INC, flush_left-- each cycle.
  - nop is ignored, because the instruction it refers to is being killed.
  - A new flush==01 reloads pc <= branch_target and flush_left <= FLUSH_CYCLES-1, and flush_count++.
  - Exit to RUN when flush_left reaches 0.
- Simultaneous flush==01 and nop==01 in any state: flush wins; the nop is dropped and not counted.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-STALL or mid-FLUSH: immediate return to reset values, with no pending action carried over.
- FLUSH_CYCLES outside 1..3 is a configuration error. Flag it with an elaboration-time assertion.

Test Plan:
- Reset release with idle inputs: pc steps 0,1,2,3. Outputs: if_id_en=1, if_id_clear=0, id_ex_bubble=0, busy=0, counters 0.
- nop=01 for 2 cycles at pc=5:
  - pc stays 5 for 2 cycles; if_id_en=0 and id_ex_bubble=1 for both cycles; stall_count=2.
  - Third cycle: pc=6, busy=0.
- flush=01 with branch_target=0x0040 at pc=9: next pc=0x0040; if_id_clear=1 for one cycle; flush_count=1; state stays RUN.
- nop=01 and flush=01 together, branch_target=0x0100: pc=0x0100, stall_count unchanged, flush_count+1.
- FLUSH_CYCLES=3, flush at pc=2 with target 0x20:
  - if_id_clear high for 3 cycles; pc sequence 0x20,0x21,0x22.
  - nop pulsed during the FLUSH cycles is ignored.
  - busy=1 for 2 cycles.
- flush=2'b11 for one cycle: no redirect, pc increments normally, illegal_req=1 and stays 1 until rst_n is pulsed low mid-stall, which returns every output to its reset value.
